// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
package mult_arb_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } mult_arb_state_t;

   localparam int OPCNT_W = 16;
endpackage

// File: rtl/Mult.sv
// Unsigned combinational N x N multiplier datapath with an exact 2N-bit product.
module Mult #(
   parameter int N = 4
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] c
);
   assign c = {{N{1'b0}}, a} * {{N{1'b0}}, b};
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1, modulo NREQ.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_any
);
   always_comb begin
      int unsigned idx;
      logic [IW-1:0] sel;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(last) + k) % NREQ;
         sel = IW'(idx);
         if (!gnt_any && req[sel]) begin
            gnt[sel] = 1'b1;
            gnt_idx  = sel;
            gnt_any  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one Mult datapath among NREQ requesters (IDLE -> CALC -> RESP).
// MULT_ARB_CNT_EN builds a saturating count of consumed results on op_count.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int NREQ = 2,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*N-1:0]  req_a,
   input  logic [NREQ*N-1:0]  req_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*N-1:0]     res_c,
   output logic               res_v,
   output logic [IW-1:0]      res_id,
   output logic [OPCNT_W-1:0] op_count
);
   mult_arb_state_t state, state_nx;
   logic [IW-1:0]   last;
   logic [IW-1:0]   gnt_idx;
   logic [NREQ-1:0] gnt;
   logic            gnt_any;
   logic [N-1:0]    op_a, op_b;
   logic [2*N-1:0]  prod;
   logic            take, done;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (req_valid),
      .last    (last),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   Mult #(.N(N)) u_mult (
      .a (op_a),
      .b (op_b),
      .c (prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      res_valid = 1'b0;
      take      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = gnt;
            if (gnt_any) begin
               take     = 1'b1;
               state_nx = CALC;
            end
         end
         CALC: state_nx = RESP;
         RESP: begin
            res_valid = 1'b1;
            if (res_ready) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // last starts at NREQ-1 so requester 0 wins the first arbitration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last   <= IW'(NREQ - 1);
         op_a   <= '0;
         op_b   <= '0;
         res_c  <= '0;
         res_v  <= 1'b0;
         res_id <= '0;
      end else begin
         if (take) begin
            op_a   <= req_a[gnt_idx*N +: N];
            op_b   <= req_b[gnt_idx*N +: N];
            res_id <= gnt_idx;
         end
         if (state == CALC) begin
            res_c <= prod;
            res_v <= |prod[2*N-1:N];
         end
         if (done) last <= res_id;
      end
   end

`ifdef MULT_ARB_CNT_EN
   logic [OPCNT_W-1:0] cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   cnt <= '0;
      else if (done && cnt != '1) cnt <= cnt + 1'b1;
   end
   assign op_count = cnt;
`else
   assign op_count = '0;
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a cycle model predicts grants and results.
module tb_mult_arbiter;
   localparam int N    = 4;
   localparam int NREQ = 2;
   localparam int IW   = 1;
`ifdef MULT_ARB_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a, req_b;
   logic              res_valid, res_ready;
   logic [2*N-1:0]    res_c;
   logic              res_v;
   logic [IW-1:0]     res_id;
   logic [15:0]       op_count;

   always #5 clk = ~clk;

   mult_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_c     (res_c),
      .res_v     (res_v),
      .res_id    (res_id),
      .op_count  (op_count)
   );

   typedef struct packed {
      logic [7:0]    c;
      logic          v;
      logic [IW-1:0] id;
   } exp_t;
   typedef enum int {M_IDLE, M_CALC, M_RESP} mst_t;

   exp_t          sb[$];
   int            ids[$];
   mst_t          m_state = M_IDLE;
   logic [IW-1:0] m_last  = '1;
   int            n_done  = 0;
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model, evaluated mid-cycle while inputs are stable
   always @(negedge clk) begin
      logic [NREQ-1:0] exp_rdy;
      logic [N-1:0]    a, b;
      logic [7:0]      p;
      exp_t            e;
      mst_t            cur;
      int              g, idx;
      if (rst) begin
         m_state = M_IDLE;
         m_last  = IW'(NREQ - 1);
         sb.delete();
         check_eq("rst_req_ready", 32'(req_ready), 0);
         check_eq("rst_res_valid", 32'(res_valid), 0);
         check_eq("rst_res_c",     32'(res_c), 0);
         check_eq("rst_res_v",     32'(res_v), 0);
         check_eq("rst_res_id",    32'(res_id), 0);
         check_eq("rst_op_count",  32'(op_count), 0);
      end else begin
         cur     = m_state;
         exp_rdy = '0;
         case (cur)
            M_IDLE: begin
               g = -1;
               for (int k = 1; k <= NREQ; k++) begin
                  idx = (int'(m_last) + k) % NREQ;
                  if (g < 0 && req_valid[idx]) g = idx;
               end
               if (g >= 0) begin
                  exp_rdy[g] = 1'b1;
                  a    = req_a[g*N +: N];
                  b    = req_b[g*N +: N];
                  p    = {4'b0, a} * {4'b0, b};
                  e.c  = p;
                  e.v  = (p[7:4] != 4'd0);
                  e.id = IW'(g);
                  sb.push_back(e);
                  m_state = M_CALC;
               end
            end
            M_CALC: m_state = M_RESP;
            M_RESP: begin
               if (res_ready) begin
                  if (sb.size() == 0) begin
                     check_eq("sb_underflow", 32'(sb.size()), 1);
                  end else begin
                     e = sb.pop_front();
                     check_eq("res_c",  32'(res_c),  32'(e.c));
                     check_eq("res_v",  32'(res_v),  32'(e.v));
                     check_eq("res_id", 32'(res_id), 32'(e.id));
                     m_last = e.id;
                  end
                  ids.push_back(int'(res_id));
                  n_done++;
                  m_state = M_IDLE;
               end
            end
            default: m_state = M_IDLE;
         endcase
         check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
         check_eq("res_valid", 32'(res_valid), 32'(cur == M_RESP));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_state(input mst_t s, input string tag);
      int t = 0;
      while (m_state != s && t < 50) begin
         step();
         t++;
      end
      if (m_state != s) check_eq(tag, 32'(m_state), 32'(s));
   endtask

   task automatic wait_done(input int target, input string tag);
      int t = 0;
      while (n_done < target && t < 300) begin
         step();
         t++;
      end
      if (n_done < target) check_eq(tag, 32'(n_done), 32'(target));
   endtask

   initial begin
      int base;
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // single request with latency check
      res_ready = 1'b1;
      req_a = {4'd0, 4'd3}; req_b = {4'd0, 4'd5}; req_valid = 2'b01;
      wait_state(M_CALC, "hs_single");
      req_valid = '0;
      @(negedge clk);
      check_eq("lat_calc_valid", 32'(res_valid), 0);
      @(negedge clk);
      check_eq("lat_resp_valid", 32'(res_valid), 1);
      check_eq("single_c",  32'(res_c), 15);
      check_eq("single_v",  32'(res_v), 0);
      check_eq("single_id", 32'(res_id), 0);
      wait_done(1, "done_single");

      // overflow on requester 1
      req_a = {4'd15, 4'd0}; req_b = {4'd15, 4'd0}; req_valid = 2'b10;
      wait_state(M_CALC, "hs_ovf");
      req_valid = '0;
      wait_state(M_RESP, "resp_ovf");
      @(negedge clk);
      check_eq("ovf_c",  32'(res_c), 32'h E1);
      check_eq("ovf_v",  32'(res_v), 1);
      check_eq("ovf_id", 32'(res_id), 1);
      wait_done(2, "done_ovf");

      // fairness with both requesters continuously valid
      ids.delete();
      req_a = {4'd2, 4'd7}; req_b = {4'd6, 4'd9}; req_valid = 2'b11;
      wait_done(8, "done_fair");
      req_valid = '0;
      check_eq("fair_count", 32'(ids.size()), 6);
      for (int i = 0; i < ids.size() && i < 6; i++)
         check_eq($sformatf("fair_id%0d", i), 32'(ids[i]), 32'(i % 2));

      // backpressure while another request stays pending
      res_ready = 1'b0;
      req_a = {4'd1, 4'd11}; req_b = {4'd1, 4'd3}; req_valid = 2'b01;
      wait_state(M_CALC, "hs_bp");
      req_valid = 2'b11;
      wait_state(M_RESP, "resp_bp");
      repeat (10) begin
         @(negedge clk);
         check_eq("bp_c",     32'(res_c), 33);
         check_eq("bp_id",    32'(res_id), 0);
         check_eq("bp_valid", 32'(res_valid), 1);
         check_eq("bp_ready", 32'(req_ready), 0);
      end
      step();
      res_ready = 1'b1; req_valid = '0;
      step();
      @(negedge clk);
      check_eq("bp_idle_valid", 32'(res_valid), 0);
      check_eq("cnt_pre_rst", 32'(op_count), CNT_ON ? 9 : 0);

      // counter: clear, five results, then a discarded one
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check_eq("cnt_cleared", 32'(op_count), 0);
      base = n_done;
      for (int i = 0; i < 5; i++) begin
         step();
         req_a = {4'($urandom_range(15)), 4'd0};
         req_b = {4'($urandom_range(15)), 4'd0};
         req_valid = 2'b10;
         wait_state(M_CALC, "hs_cnt");
         req_valid = '0;
         wait_done(base + i + 1, "done_cnt");
      end
      @(negedge clk);
      check_eq("cnt_five", 32'(op_count), CNT_ON ? 5 : 0);

      step();
      res_ready = 1'b0;
      req_a = {4'd9, 4'd0}; req_b = {4'd13, 4'd0}; req_valid = 2'b10;
      wait_state(M_CALC, "hs_disc");
      req_valid = '0;
      wait_state(M_RESP, "resp_disc");
      rst = 1'b1;
      #1;
      check_eq("async_res_valid", 32'(res_valid), 0);
      check_eq("async_res_c",     32'(res_c), 0);
      check_eq("async_res_id",    32'(res_id), 0);
      check_eq("async_op_count",  32'(op_count), 0);
      step();
      rst = 1'b0;
      res_ready = 1'b1;
      ids.delete();
      base = n_done;
      req_a = {4'd4, 4'd6}; req_b = {4'd5, 4'd8}; req_valid = 2'b11;
      wait_done(base + 2, "done_post_rst");
      req_valid = '0;
      check_eq("post_rst_count", 32'(ids.size()), 2);
      if (ids.size() >= 2) begin
         check_eq("post_rst_first", 32'(ids[0]), 0);
         check_eq("post_rst_second", 32'(ids[1]), 1);
      end
      @(negedge clk);
      check_eq("cnt_after_disc", 32'(op_count), CNT_ON ? 2 : 0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin controller that shares one combinational N-bit multiplier between NREQ requesters. Each requester offers an operand pair with a valid/ready handshake. The block grants one requester, latches its operands, and registers the 2N-bit product plus overflow flag. It then holds the result on a valid/ready output port until it is consumed. It sits between the requesting units and the existing `Mult #(N)` datapath.

## Interface
- `N`, 4: operand width in bits.
- `NREQ`, 2: number of requesters; must be ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  request i is offering operands.
- `req_ready`  out  NREQ  one-hot grant/accept; at most one bit high.
- `req_a`  in  NREQ*N  operand A; requester i uses bits [i*N +: N].
- `req_b`  in  NREQ*N  operand B; same packing as `req_a`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_c`  out  2N  product A*B, unsigned.
- `res_v`  out  1  overflow: high iff `res_c[2N-1:N]` is nonzero.
- `res_id`  out  $clog2(NREQ)  index of the requester that produced the result.
- `op_count`  out  16  number of completed results (see Configuration).

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - The arbiter picks grant g, the first i with `req_valid[i]=1`, searching from `last+1` upward modulo NREQ.
  - `req_ready[g]=1` combinationally. All other `req_ready` bits are 0.
  - Handshake (`req_valid[g] & req_ready[g]`): latch `req_a`/`req_b` slice g into `op_a`/`op_b`, latch g into `res_id`, go to CALC.
  - No valid request: stay in IDLE and keep every `req_ready` at 0.
- CALC:
  - `op_a`/`op_b` drive `Mult`.
  - Register the product into `res_c` and compute `res_v` = OR of `res_c[2N-1:N]`.
  - Go to RESP. `req_ready` is all 0.
- RESP:
  - `res_valid=1`; `res_c`, `res_v` and `res_id` are held stable.
  - When `res_ready=1`, the result is consumed: update `last <= res_id`, go to IDLE.
  - Otherwise stay in RESP (backpressure holds indefinitely).
- `req_ready` is 0 in every state except IDLE.
- Operands are unsigned. The product is exact in 2N bits, so it never truncates.
- A requester whose `req_valid` is dropped before grant loses nothing. A grant only counts on a handshake.

## Timing
- Reset values:
  - FSM = IDLE, `last` = NREQ-1, so requester 0 wins first.
  - `req_ready=0`, `res_valid=0`, `res_c=0`, `res_v=0`, `res_id=0`, `op_count=0`.
- Latency:
  - Handshake on edge k; product registered on edge k+1; `res_valid` high in the cycle after edge k+1.
  - With `res_ready` tied high, the result is consumed on edge k+2 and the next grant handshake can occur on edge k+3.
  - Peak throughput is therefore one operation per 3 cycles.
- All requesters valid continuously: grants rotate 0,1,…,NREQ-1,0,… with no starvation. Worst-case wait is NREQ-1 services.
- A request that becomes valid in the same cycle as the IDLE arbitration is eligible that cycle.
- `rst` asserted in any state returns all state to reset values immediately. Any in-flight result is discarded and not counted.

## Configuration
- `MULT_ARB_CNT_EN` defined:
  - `op_count` increments by 1 on each result consumption (RESP & `res_ready`).
  - It saturates at 16'hFFFF.
- `MULT_ARB_CNT_EN` undefined: `op_count` is tied to 0 and no counter register is built. The port list is unchanged.

## Structure
- Package `mult_arb_pkg`: FSM state typedef `mult_arb_state_t` {IDLE, CALC, RESP} and constant `OPCNT_W = 16`.
- Sub-module `rr_arbiter #(NREQ)`:
  - Inputs: `req[NREQ]`, `last`.
  - Outputs: one-hot `gnt` and its binary index.
  - Purely combinational.
- `Mult #(N)` is instantiated unchanged as the datapath.

## Test plan
All tests use N=4 and NREQ=2.
- Reset: assert `rst` mid-RESP → all outputs 0, FSM in IDLE in the same cycle. The first grant after release goes to requester 0.
- Single request: req0 A=3, B=5 → `res_c`=15, `res_v`=0, `res_id`=0, `res_valid` high 2 cycles after the handshake.
- Overflow: req1 A=15, B=15 → `res_c`=225 (8'hE1), `res_v`=1, `res_id`=1.
- Fairness: both valid continuously, `res_ready`=1, six operations → `res_id` sequence 0,1,0,1,0,1.
- Backpressure: hold `res_ready`=0 for 10 cycles in RESP → `res_c`/`res_id` stable, `req_ready` stays 0. Raise `res_ready` → consumed, back to IDLE next cycle.
- Counter with `MULT_ARB_CNT_EN` defined: five consumed results → `op_count`=5; a result discarded by reset is not counted. Without the macro, `op_count` stays 0.
